// File: rtl/dm_cache_pkg.sv
// Shared types and helpers for the direct-mapped read-only cache controller.
// Holds the controller state encoding, block geometry constants and the
// address-field extraction helpers used by the top and the storage array.
package dm_cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        FILL,
        RESP
    } state_t;

    localparam int OFFSET_W    = 2;
    localparam int BLOCK_WORDS = 4;

    // Word offset inside a block (low address bits).
    function automatic logic [31:0] addrOffset(input logic [31:0] addr);
        return addr & 32'(BLOCK_WORDS - 1);
    endfunction

    // Line index: the idxW bits just above the block offset.
    function automatic logic [31:0] addrIndex(input logic [31:0] addr, input int idxW);
        return (addr >> OFFSET_W) & ((32'd1 << idxW) - 32'd1);
    endfunction

    // Tag: everything above offset and index.
    function automatic logic [31:0] addrTag(input logic [31:0] addr, input int idxW);
        return addr >> (OFFSET_W + idxW);
    endfunction

endpackage

// File: rtl/dm_cache_array.sv
// Valid/tag/data storage for the direct-mapped cache.
// One synchronous write port fills a whole line; one combinational read port
// returns valid, tag and the four block words of the indexed line.
// Only the valid bits are reset (asynchronously); tags and data are not.
module dm_cache_array
    import dm_cache_pkg::*;
#(
    parameter int LINES = 1024,
    parameter int TAG_W = 3
) (
    input  logic                                clk,
    input  logic                                rstN,
    input  logic                                wrEn,
    input  logic [$clog2(LINES)-1:0]            wrIndex,
    input  logic [TAG_W-1:0]                    wrTag,
    input  logic [BLOCK_WORDS-1:0][31:0]        wrData,
    input  logic [$clog2(LINES)-1:0]            rdIndex,
    output logic                                rdValid,
    output logic [TAG_W-1:0]                    rdTag,
    output logic [BLOCK_WORDS-1:0][31:0]        rdData
);

    logic [LINES-1:0]                validBits;
    logic [TAG_W-1:0]                tagMem  [LINES];
    logic [BLOCK_WORDS-1:0][31:0]    dataMem [LINES];

    // Valid bits: cleared by reset so an interrupted fill never leaves a live line.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            validBits <= '0;
        end else if (wrEn) begin
            validBits[wrIndex] <= 1'b1;
        end
    end

    // Tag and data storage: written only when a fill completes, never reset.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            tagMem[wrIndex]  <= wrTag;
            dataMem[wrIndex] <= wrData;
        end
    end

    assign rdValid = validBits[rdIndex];
    assign rdTag   = tagMem[rdIndex];
    assign rdData  = dataMem[rdIndex];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped read-only data cache controller between a load port and a
// main memory that returns a 4-word block combinationally.
// Hits are served from the line array; misses fetch the block after a fixed
// latency, fill the line and then return the requested word.
// Optional feature macro: CACHE_STATS_EN adds hitCount/missCount ports.
module dm_cache_ctrl
    import dm_cache_pkg::*;
#(
    parameter int LINES       = 1024,
    parameter int MEM_LATENCY = 4,
    parameter int ADDR_W      = 15
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              reqValid,
    input  logic [ADDR_W-1:0] reqAddr,
    output logic              reqReady,
    output logic              respValid,
    output logic [31:0]       respData,
    output logic [ADDR_W-1:0] memAddr,
    input  logic [31:0]       w3,
    input  logic [31:0]       w2,
    input  logic [31:0]       w1,
    input  logic [31:0]       w0
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hitCount,
    output logic [31:0]       missCount
`endif
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    state_t                       state;
    state_t                       nextState;
    logic                         armed;
    logic [ADDR_W-1:0]            latAddr;
    logic [IDX_W-1:0]             latIdx;
    logic [TAG_W-1:0]             latTag;
    logic [OFFSET_W-1:0]          latOff;
    logic [CNT_W-1:0]             waitCnt;
    logic                         rdValid;
    logic [TAG_W-1:0]             rdTag;
    logic [BLOCK_WORDS-1:0][31:0] rdData;
    logic [BLOCK_WORDS-1:0][31:0] fillData;
    logic                         hit;
    logic                         fillDone;

    assign latIdx   = IDX_W'(addrIndex(32'(latAddr), IDX_W));
    assign latTag   = TAG_W'(addrTag(32'(latAddr), IDX_W));
    assign latOff   = OFFSET_W'(addrOffset(32'(latAddr)));
    assign fillData = {w3, w2, w1, w0};
    assign hit      = rdValid && (rdTag == latTag);
    assign fillDone = (state == FILL) && (waitCnt == '0);

    assign reqReady  = (state == IDLE);
    assign respValid = (state == RESP);

    dm_cache_array #(
        .LINES (LINES),
        .TAG_W (TAG_W)
    ) lineArray (
        .clk     (clk),
        .rstN    (rstN),
        .wrEn    (fillDone),
        .wrIndex (latIdx),
        .wrTag   (latTag),
        .wrData  (fillData),
        .rdIndex (latIdx),
        .rdValid (rdValid),
        .rdTag   (rdTag),
        .rdData  (rdData)
    );

    // State register; armed stays low for the first edge after reset release so a request then is ignored.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= nextState;
            armed <= 1'b1;
        end
    end

    // Next-state logic for the lookup / fill / respond sequence.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (reqValid && armed) nextState = LOOKUP;
            LOOKUP:  nextState = hit ? RESP : FILL;
            FILL:    if (waitCnt == '0) nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Datapath: latch the request, run the memory wait counter, hold memAddr and capture the response word.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            latAddr  <= '0;
            waitCnt  <= '0;
            memAddr  <= '0;
            respData <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (reqValid && armed) latAddr <= reqAddr;
                end
                LOOKUP: begin
                    if (hit) begin
                        respData <= rdData[latOff];
                    end else begin
                        waitCnt <= CNT_LOAD;
                        memAddr <= {latTag, latIdx, {OFFSET_W{1'b0}}};
                    end
                end
                FILL: begin
                    if (waitCnt == '0) respData <= fillData[latOff];
                    else               waitCnt  <= waitCnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    // Hit/miss statistics, counted once per request in its lookup cycle.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            hitCount  <= '0;
            missCount <= '0;
        end else if (state == LOOKUP) begin
            if (hit) hitCount  <= hitCount + 32'd1;
            else     missCount <= missCount + 32'd1;
        end
    end
`endif

endmodule
